// File: rtl/exmem_arbiter.sv
// Two-port arbiter/sequencer in front of the 256x8 exmem: one access per 3 cycles, registered outputs.
// Optional port-1 write protection of [PROT_LO, PROT_HI] is built when EXMEM_ARB_WPROT_EN is defined.
module exmem_arbiter #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned ADDR_BITS = 8,
  parameter bit          FIXED_PRI = 1'b0
`ifdef EXMEM_ARB_WPROT_EN
  ,
  parameter logic [ADDR_BITS-1:0] PROT_LO = 8'h00,
  parameter logic [ADDR_BITS-1:0] PROT_HI = 8'h3F
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 p0_req,
  input  logic                 p0_we,
  input  logic [ADDR_BITS-1:0] p0_adr,
  input  logic [WIDTH-1:0]     p0_wdata,
  output logic                 p0_ack,
  output logic [WIDTH-1:0]     p0_rdata,
  input  logic                 p1_req,
  input  logic                 p1_we,
  input  logic [ADDR_BITS-1:0] p1_adr,
  input  logic [WIDTH-1:0]     p1_wdata,
  output logic                 p1_ack,
  output logic [WIDTH-1:0]     p1_rdata,
  output logic                 p1_err,
  output logic                 mem_en,
  output logic                 mem_memwrite,
  output logic [ADDR_BITS-1:0] mem_adr,
  output logic [WIDTH-1:0]     mem_wdata,
  input  logic [WIDTH-1:0]     mem_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_win, r_rr_pri;
  logic                  r_mem_en, r_mem_we;
  logic [ADDR_BITS-1:0]  r_mem_adr;
  logic [WIDTH-1:0]      r_mem_wdata;
  logic                  r_p0_ack, r_p1_ack;
  logic [WIDTH-1:0]      r_p0_rdata, r_p1_rdata;
  logic                  w_win, w_sel_we, w_blocked;
  logic [ADDR_BITS-1:0]  w_sel_adr;
  logic [WIDTH-1:0]      w_sel_wdata;

`ifdef EXMEM_ARB_WPROT_EN
  localparam logic [ADDR_BITS-1:0] PROT_SPAN = PROT_HI - PROT_LO;
  logic                 r_blk, r_p1_err;
  logic [ADDR_BITS-1:0] w_prot_off;
  // Offset-from-base compare avoids an always-true "adr >= 0" when PROT_LO is 0
  assign w_prot_off = p1_adr - PROT_LO;
  assign p1_err     = r_p1_err;
`else
  assign p1_err = 1'b0;
`endif

  always_comb begin
    w_state_nxt = S_IDLE;
    case (r_state)
      S_IDLE:   w_state_nxt = (p0_req || p1_req) ? S_ACCESS : S_IDLE;
      S_ACCESS: w_state_nxt = S_DONE;
      S_DONE:   w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // Winner selection; r_rr_pri names the port favoured on the next tie
  always_comb begin
    if (p0_req && p1_req) w_win = FIXED_PRI ? 1'b0 : r_rr_pri;
    else                  w_win = p1_req;
    w_sel_we    = w_win ? p1_we    : p0_we;
    w_sel_adr   = w_win ? p1_adr   : p0_adr;
    w_sel_wdata = w_win ? p1_wdata : p0_wdata;
    w_blocked   = 1'b0;
`ifdef EXMEM_ARB_WPROT_EN
    w_blocked   = w_win && p1_we && (w_prot_off <= PROT_SPAN);
`endif
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_win       <= 1'b0;
      r_rr_pri    <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_adr   <= '0;
      r_mem_wdata <= '0;
      r_p0_ack    <= 1'b0;
      r_p1_ack    <= 1'b0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
`ifdef EXMEM_ARB_WPROT_EN
      r_blk       <= 1'b0;
      r_p1_err    <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          r_p0_ack <= 1'b0;
          r_p1_ack <= 1'b0;
`ifdef EXMEM_ARB_WPROT_EN
          r_p1_err <= 1'b0;
          r_blk    <= w_blocked;
`endif
          r_mem_en <= p0_req || p1_req;
          if (p0_req || p1_req) begin
            r_mem_we    <= w_sel_we && !w_blocked;
            r_mem_adr   <= w_sel_adr;
            r_mem_wdata <= w_sel_wdata;
            r_win       <= w_win;
            r_rr_pri    <= !w_win;
          end
        end
        S_ACCESS: begin
          r_mem_en <= 1'b0;
          r_mem_we <= 1'b0;
          if (r_win) begin
            r_p1_ack   <= 1'b1;
            r_p1_rdata <= mem_rdata;
`ifdef EXMEM_ARB_WPROT_EN
            r_p1_err   <= r_blk;
`endif
          end else begin
            r_p0_ack   <= 1'b1;
            r_p0_rdata <= mem_rdata;
          end
        end
        default: begin
          r_p0_ack <= 1'b0;
          r_p1_ack <= 1'b0;
`ifdef EXMEM_ARB_WPROT_EN
          r_p1_err <= 1'b0;
`endif
        end
      endcase
    end
  end

  assign p0_ack       = r_p0_ack;
  assign p0_rdata     = r_p0_rdata;
  assign p1_ack       = r_p1_ack;
  assign p1_rdata     = r_p1_rdata;
  assign mem_en       = r_mem_en;
  assign mem_memwrite = r_mem_we;
  assign mem_adr      = r_mem_adr;
  assign mem_wdata    = r_mem_wdata;

endmodule
